// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and the default datapath width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } state_e;

    function automatic logic op_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes going into the unsigned core,
// and sign/divide-by-zero correction of the raw core result coming out.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    input  logic [1:0]       res_op,
    input  logic [WIDTH-1:0] res_opa,
    input  logic [WIDTH-1:0] res_opb,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    logic               sign_diff;
    logic               rem_neg;
    logic [2*WIDTH-1:0] prod;

    assign mag_a = (op_signed(op) && opa[WIDTH-1]) ? -opa : opa;
    assign mag_b = (op_signed(op) && opb[WIDTH-1]) ? -opb : opb;

    assign prod      = {raw_hi, raw_lo};
    assign sign_diff = op_signed(res_op) && (res_opa[WIDTH-1] ^ res_opb[WIDTH-1]);
    // Remainder follows the dividend so that quotient*divisor + remainder == dividend.
    assign rem_neg   = op_signed(res_op) && res_opa[WIDTH-1];

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        fix_hi = raw_hi;
        fix_lo = raw_lo;
        if (!op_is_div(res_op)) begin
            {fix_hi, fix_lo} = sign_diff ? -prod : prod;
        end else if (res_opb == '0) begin
            fix_hi = res_opa;
            fix_lo = '1;
        end else begin
            if (sign_diff) fix_lo = -raw_lo;
            if (rem_neg)   fix_hi = -raw_hi;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle shift-add multiply or
// restoring divide on magnitudes, with cancel and direct HI/LO writes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state, state_nxt;
    op_e              op_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [WIDTH-1:0] acc_hi, acc_lo, mb;
    logic [CW-1:0]    count;
    logic             accept, step, fin_write;
    logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo;
    logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op      (op),
        .opa     (opa),
        .opb     (opb),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .res_op  (op_q),
        .res_opa (opa_q),
        .res_opb (opb_q),
        .raw_hi  (acc_hi),
        .raw_lo  (acc_lo),
        .fix_hi  (fix_hi),
        .fix_lo  (fix_lo)
    );

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        fin_write = 1'b0;
        case (state)
            S_IDLE: if (start && !cancel) begin
                accept    = 1'b1;
                state_nxt = S_CALC;
            end
            S_CALC: if (cancel) begin
                state_nxt = S_IDLE;
            end else begin
                step = 1'b1;
                if (count == LAST) state_nxt = S_FIN;
            end
            S_FIN: begin
                fin_write = !cancel;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Multiply keeps {acc_hi, acc_lo} as partial product : remaining multiplier bits;
    // divide keeps them as partial remainder : quotient being shifted in.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mb} : '0);
    assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, mb};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= OP_MULT;
            opa_q  <= '0;
            opb_q  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mb     <= '0;
            count  <= '0;
        end else if (accept) begin
            op_q   <= op_e'(op);
            opa_q  <= opa;
            opb_q  <= opb;
            acc_hi <= '0;
            acc_lo <= mag_a;
            mb     <= mag_b;
            count  <= '0;
        end else if (step) begin
            count <= count + CW'(1);
            if (op_is_div(op_q)) begin
                if (!rem_diff[WIDTH]) begin
                    acc_hi <= rem_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= rem_sh[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= fin_write;
            if (fin_write) begin
                hi <= fix_hi;
                lo <= fix_lo;
                if (op_is_div(op_q)) div_zero <= (opb_q == '0);
            end else if (state == S_IDLE && !start) begin
                if (wr_hi) hi <= wr_data;
                if (wr_lo) lo <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: hand-computed products, quotients,
// cancel/reset behaviour and HI/LO direct writes.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, cancel, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] opa, opb, wr_data;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .cancel   (cancel),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept edge is cycle 0; cycle k is the interval after the k-th following edge.
    // cancel_at < 0 means no cancel. poke drives a start and HI/LO writes while busy.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int cancel_at, input bit poke);
        int cyc, done_cyc, n_done;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; opa = '0; opb = '0;
        check({tag, "_busy_c0"}, busy, 1);
        cyc = 0; done_cyc = -1; n_done = 0;
        while (cyc < 40) begin
            if (poke && cyc == 5) begin
                start = 1'b1; op = 2'b11; opa = 32'd1; opb = 32'd1;
                wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEADBEEF;
            end
            if (cyc == cancel_at) cancel = 1'b1;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; cancel = 1'b0;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cancel_at < 0 && cyc == 32) check({tag, "_busy_c32"}, busy, 1);
            if (cancel_at < 0 && cyc == 33) check({tag, "_busy_c33"}, busy, 0);
            if (cancel_at >= 0 && cyc == cancel_at) check({tag, "_busy_at_cancel"}, busy, 1);
            if (cancel_at >= 0 && cyc == cancel_at + 1) check({tag, "_busy_after_cancel"}, busy, 0);
        end
        if (cancel_at < 0) begin
            check({tag, "_done_cycle"}, done_cyc, 33);
            check({tag, "_done_count"}, n_done, 1);
        end else begin
            check({tag, "_done_count"}, n_done, 0);
        end
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = 2'b00; opa = '0; opb = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        check("rst_hilo", {hi, lo}, 64'h0);
        rst = 1'b1;

        run_op("mult_neg", 2'b00, 32'hFFFFFFFB, 32'h00000006, -1, 1'b0);
        check("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFE2);

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b1);
        check("multu_max_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        run_op("divu_17_3", 2'b11, 32'd17, 32'd3, -1, 1'b0);
        check("divu_17_3_hilo", {hi, lo}, {32'd2, 32'd5});
        check("divu_17_3_dz", div_zero, 0);

        run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
        check("div_m7_2_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
        check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

        run_op("divu_zero", 2'b11, 32'h12345678, 32'h0, -1, 1'b0);
        check("divu_zero_hilo", {hi, lo}, 64'h12345678_FFFFFFFF);
        check("divu_zero_dz", div_zero, 1);

        run_op("mult_keep_dz", 2'b00, 32'd3, 32'd4, -1, 1'b0);
        check("mult_keep_dz_hilo", {hi, lo}, 64'h00000000_0000000C);
        check("mult_keep_dz_dz", div_zero, 1);

        run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, -1, 1'b0);
        check("div_7_m2_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);
        check("div_7_m2_dz", div_zero, 0);

        run_op("cancel_c10", 2'b00, 32'd5, 32'd5, 10, 1'b1);
        check("cancel_c10_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);

        run_op("cancel_fin", 2'b11, 32'd5, 32'd0, 32, 1'b0);
        check("cancel_fin_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);
        check("cancel_fin_dz", div_zero, 0);

        // start together with cancel in IDLE: not accepted, and the write is dropped too
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 2'b00; opa = 32'd2; opb = 32'd3;
        wr_lo = 1'b1; wr_data = 32'h0000AAAA;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; wr_lo = 1'b0;
        check("start_cancel_busy", busy, 0);
        check("start_cancel_lo", lo, 32'hFFFFFFFD);

        wr_hi = 1'b1; wr_data = 32'h00000005;
        @(posedge clk);
        @(negedge clk);
        wr_hi = 1'b0;
        check("wr_hi_hilo", {hi, lo}, 64'h00000005_FFFFFFFD);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; op = 2'b01; opa = 32'd9; opb = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_dz", div_zero, 0);
        check("rst_mid_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        run_op("after_rst", 2'b01, 32'd2, 32'd3, -1, 1'b0);
        check("after_rst_hilo", {hi, lo}, 64'h00000000_00000006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (>=4, even).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  operation request, sampled on a rising edge.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports opa, opb  input  WIDTH  multiplicand/dividend, multiplier/divisor.
REQ-007 SHALL have port cancel  input  1  pipeline flush; aborts an in-flight operation.
REQ-008 SHALL have ports wr_hi, wr_lo  input  1  direct HI/LO write enables (MTHI/MTLO).
REQ-009 SHALL have port wr_data  input  WIDTH  data for wr_hi/wr_lo.
REQ-010 SHALL have port busy  output  1  high while an operation is in flight.
REQ-011 SHALL have port done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-012 SHALL have port div_zero  output  1  sticky flag: the last completed divide had opb==0.
REQ-013 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> FIN -> IDLE.
REQ-015 In IDLE, start=1 and cancel=0 SHALL latch op, opa and opb and enter CALC; busy rises on the next cycle.
REQ-016 CALC SHALL run exactly WIDTH cycles, one bit per cycle: shift-add multiply or restoring divide, on operand magnitudes.
REQ-017 FIN SHALL apply sign correction, write HI/LO, pulse done for one cycle, then return to IDLE.
REQ-018 done SHALL be asserted WIDTH+1 cycles after the edge that accepted start; busy is high for WIDTH+1 cycles.
REQ-019 MULT/MULTU SHALL produce HI:LO = full 2*WIDTH-bit product, signed or unsigned respectively.
REQ-020 DIV/DIVU SHALL produce LO = quotient truncated toward zero and HI = remainder; the remainder takes the sign of the dividend.
REQ-021 DIV with opa = minimum signed value and opb = -1 SHALL give LO = minimum value and HI = 0, with no exception.
REQ-022 Divide by zero SHALL give LO = all ones and HI = opa, and set div_zero; any other completed divide clears div_zero, and multiplies leave it unchanged.
REQ-023 start while busy SHALL be ignored, with no queuing.
REQ-024 cancel while busy SHALL return the FSM to IDLE on the next edge, with no done pulse and HI/LO/div_zero unchanged.
REQ-025 cancel in the FIN cycle SHALL suppress the HI/LO write and the done pulse.
REQ-026 cancel with start in IDLE SHALL win: the operation is not accepted.
REQ-027 wr_hi/wr_lo SHALL update HI/LO on the next edge only in IDLE without start; they are ignored when busy or when start is accepted.
REQ-028 hi/lo SHALL be readable at all times and hold old values until the FIN write.

Reset
REQ-029 rst low SHALL immediately force IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, and clear the internal datapath.
REQ-030 Reset mid-operation SHALL discard the operation; the first start after rst deasserts is accepted normally.

Structure
REQ-031 Op encodings, the FSM state enum and the WIDTH default SHALL live in shared package muldiv_pkg.
REQ-032 Magnitude and sign correction SHALL be one combinational sub-module, muldiv_sign_fix; the FSM and datapath stay in muldiv_unit.

Verification (WIDTH=32)
REQ-033 MULT opa=FFFFFFFB, opb=00000006 -> done at cycle 33, hi=FFFFFFFF, lo=FFFFFFE2.
REQ-034 MULTU opa=FFFFFFFF, opb=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; DIVU 17/3 -> lo=5, hi=2.
REQ-035 DIV opa=FFFFFFF9, opb=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-036 DIVU opa=12345678, opb=0 -> lo=FFFFFFFF, hi=12345678, div_zero=1; a following MULT keeps div_zero=1.
REQ-037 MULT started, then cancel at cycle 10 -> no done, busy low at cycle 11, hi/lo unchanged; start during busy ignored.
REQ-038 wr_hi=1, wr_data=00000005 in IDLE -> hi=00000005, lo unchanged; rst low mid-CALC -> all outputs 0 immediately.
